dj8_cpu: RTL and testbench



---
 rtl/dj8_pkg.sv | 50 +++++
 rtl/dj8_alu.sv | 68 ++++++
 rtl/dj8_cpu.sv | 179 +++++++++++++++++
 tb/tb_dj8_cpu.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dj8_pkg.sv
// dj8_pkg: shared types and constants for the dj8 8-bit accumulator CPU.
// Optional feature macro: DJ8_SHIFT_EN (register-form shift-right with carry).
package dj8_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_ADDC = 3'd1,
        ALU_SUBC = 3'd2,
        ALU_SUB  = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_OR   = 3'd5,
        ALU_AND  = 3'd6,
        ALU_MOV  = 3'd7
    } alu_op_t;

    typedef enum logic [2:0] {
        CLS_NOP   = 3'd0,
        CLS_JCOND = 3'd1,
        CLS_JGH   = 3'd2,
        CLS_REG   = 3'd3,
        CLS_IMM   = 3'd4
    } ins_cls_t;

    typedef enum logic [1:0] {
        ST_FETCH_HI = 2'd0,
        ST_FETCH_LO = 2'd1,
        ST_EXEC     = 2'd2,
        ST_WRITE    = 2'd3
    } state_t;

    localparam logic [15:0] RESET_PC = 16'h8000;

    // IR[15:12] values for the immediate-target jump group
    localparam logic [3:0] JOP_JZ  = 4'd1;
    localparam logic [3:0] JOP_JNZ = 4'd2;
    localparam logic [3:0] JOP_JMP = 4'd3;

    // Instruction class from the top nibble of the opcode byte.
    function automatic ins_cls_t decode_class(input logic [3:0] top);
        ins_cls_t cls;
        case (top[3:2])
            2'b00:   cls = (top[1:0] == 2'b00) ? CLS_NOP : CLS_JCOND;
            2'b01:   cls = CLS_JGH;
            2'b10:   cls = CLS_REG;
            default: cls = CLS_IMM;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/dj8_alu.sv
// dj8_alu: combinational 8-bit ALU with optional logical shift-right of the result.
// With DJ8_SHIFT_EN undefined, i_shr is ignored.
module dj8_alu
    import dj8_pkg::*;
(
    input  logic [7:0] i_x,
    input  logic [7:0] i_y,
    input  logic       i_c_in,
    input  alu_op_t    i_op,
    input  logic       i_shr,
    output logic [7:0] o_result,
    output logic       o_c_out,
    output logic       o_z
);

    logic [8:0] w_sum;
    logic [7:0] w_pre;
    logic       w_c_pre;

`ifndef DJ8_SHIFT_EN
    logic w_unused_shr;
    assign w_unused_shr = i_shr;
`endif

    // Arithmetic/logic result, carry (add) or borrow (subtract), then optional shift.
    always_comb begin
        w_sum   = 9'd0;
        w_pre   = 8'd0;
        w_c_pre = i_c_in;
        case (i_op)
            ALU_ADD: begin
                w_sum   = {1'b0, i_x} + {1'b0, i_y};
                w_pre   = w_sum[7:0];
                w_c_pre = w_sum[8];
            end
            ALU_ADDC: begin
                w_sum   = {1'b0, i_x} + {1'b0, i_y} + {8'd0, i_c_in};
                w_pre   = w_sum[7:0];
                w_c_pre = w_sum[8];
            end
            ALU_SUBC: begin
                w_sum   = {1'b0, i_x} - {1'b0, i_y} - {8'd0, i_c_in};
                w_pre   = w_sum[7:0];
                w_c_pre = w_sum[8];
            end
            ALU_SUB: begin
                w_sum   = {1'b0, i_x} - {1'b0, i_y};
                w_pre   = w_sum[7:0];
                w_c_pre = w_sum[8];
            end
            ALU_XOR: w_pre = i_x ^ i_y;
            ALU_OR:  w_pre = i_x | i_y;
            ALU_AND: w_pre = i_x & i_y;
            default: w_pre = i_y;
        endcase

        o_result = w_pre;
        o_c_out  = w_c_pre;
`ifdef DJ8_SHIFT_EN
        if (i_shr) begin
            o_result = {1'b0, w_pre[7:1]};
            o_c_out  = w_pre[0];
        end
`endif
        o_z = (o_result == 8'd0);
    end

endmodule

// File: rtl/dj8_cpu.sv
// dj8_cpu: 8-bit accumulator CPU, registers A-H, 16-bit instructions,
// one shared address bus for fetch, load and store.
// Optional feature macro: DJ8_SHIFT_EN (IR[2] shift-right in register form).
//
// state       | meaning
// ------------+-------------------------------------------------------
// ST_FETCH_HI | address_out=PC, capture IR[15:8]
// ST_FETCH_LO | address_out=PC+1, capture IR[7:0], PC += 2
// ST_EXEC     | execute; load/store drive the pointer, store raises we
// ST_WRITE    | store data cycle: we=1, write_cycle=1, data_out=src
module dj8_cpu
    import dj8_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data_in,
    output logic [15:0] address_out,
    output logic [7:0]  data_out,
    output logic        we,
    output logic        write_cycle
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic [7:0]  r_regs [0:7];
    logic        r_z;
    logic        r_c;

    ins_cls_t    w_cls;
    alu_op_t     w_op;
    logic [2:0]  w_dst;
    logic [2:0]  w_src;
    logic [15:0] w_ptr;
    logic        w_is_reg;
    logic        w_is_mem;
    logic        w_store;
    logic        w_load;
    logic        w_alu_wr;
    logic        w_jump_taken;
    logic [3:0]  w_jop;

    logic [7:0]  w_alu_x;
    logic [7:0]  w_alu_y;
    logic        w_alu_shr;
    logic [7:0]  w_alu_result;
    logic        w_alu_c;
    logic        w_alu_z;

    logic        w_unused_ir3;
    assign w_unused_ir3 = r_ir[3];

    assign w_cls    = decode_class(r_ir[15:12]);
    assign w_op     = alu_op_t'(r_ir[13:11]);
    assign w_dst    = r_ir[10:8];
    assign w_src    = r_ir[7:5];
    assign w_ptr    = r_ir[4] ? {r_regs[4], r_regs[5]} : {r_regs[6], r_regs[7]};
    assign w_is_reg = (w_cls == CLS_REG);
    assign w_is_mem = w_is_reg && (w_op == ALU_MOV);
    // Store takes priority when both the load and store bits are set.
    assign w_store  = w_is_mem && r_ir[0];
    assign w_load   = w_is_mem && r_ir[1] && !r_ir[0];
    assign w_alu_wr = (w_is_reg && !w_store && !w_load) || (w_cls == CLS_IMM);
    assign w_jop    = r_ir[15:12];

    // Flags seen here are those left by the previous instruction.
    assign w_jump_taken = (w_cls == CLS_JCOND) &&
                          ((w_jop == JOP_JMP) ||
                           ((w_jop == JOP_JZ)  &&  r_z) ||
                           ((w_jop == JOP_JNZ) && !r_z));

    // Register form computes f(src, A), except MOV which passes src through.
    // Immediate form computes f(dst, imm); IR[2] is part of the immediate there.
    always_comb begin
        w_alu_x   = r_regs[w_dst];
        w_alu_y   = r_ir[7:0];
        w_alu_shr = 1'b0;
        if (w_is_reg) begin
            w_alu_x   = r_regs[w_src];
            w_alu_y   = (w_op == ALU_MOV) ? r_regs[w_src] : r_regs[0];
            w_alu_shr = r_ir[2];
        end
    end

    dj8_alu u_alu (
        .i_x      (w_alu_x),
        .i_y      (w_alu_y),
        .i_c_in   (r_c),
        .i_op     (w_op),
        .i_shr    (w_alu_shr),
        .o_result (w_alu_result),
        .o_c_out  (w_alu_c),
        .o_z      (w_alu_z)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_FETCH_HI;
        else        r_state <= w_state_nxt;
    end

    // Next state and bus outputs; bus outputs are purely state-derived so
    // an asynchronous reset drops we at once.
    always_comb begin
        w_state_nxt = r_state;
        address_out = r_pc;
        data_out    = 8'd0;
        we          = 1'b0;
        write_cycle = 1'b0;
        case (r_state)
            ST_FETCH_HI: w_state_nxt = ST_FETCH_LO;
            ST_FETCH_LO: begin
                address_out = r_pc + 16'd1;
                w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                w_state_nxt = ST_FETCH_HI;
                if (w_store) begin
                    address_out = w_ptr;
                    we          = 1'b1;
                    w_state_nxt = ST_WRITE;
                end else if (w_load) begin
                    address_out = w_ptr;
                end
            end
            ST_WRITE: begin
                address_out = w_ptr;
                data_out    = w_alu_result;
                we          = 1'b1;
                write_cycle = 1'b1;
                w_state_nxt = ST_FETCH_HI;
            end
            default: w_state_nxt = ST_FETCH_HI;
        endcase
    end

    // Instruction capture and program counter; jumps keep PC[15:13].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
            r_ir <= 16'd0;
        end else begin
            case (r_state)
                ST_FETCH_HI: r_ir[15:8] <= data_in;
                ST_FETCH_LO: begin
                    r_ir[7:0] <= data_in;
                    r_pc      <= r_pc + 16'd2;
                end
                ST_EXEC: begin
                    if (w_jump_taken)
                        r_pc <= {r_pc[15:13], r_ir[11:0], 1'b0};
                    else if (w_cls == CLS_JGH)
                        r_pc <= {r_regs[6], r_regs[7]};
                end
                default: ;
            endcase
        end
    end

    // Register file and flags, all written at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) r_regs[i] <= 8'd0;
            r_z <= 1'b0;
            r_c <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            if (w_load) begin
                r_regs[w_dst] <= data_in;
                r_z           <= (data_in == 8'd0);
            end else if (w_alu_wr) begin
                r_regs[w_dst] <= w_alu_result;
                r_z           <= w_alu_z;
                r_c           <= w_alu_c;
            end
        end
    end

endmodule

// File: tb/tb_dj8_cpu.sv
// tb_dj8_cpu: instruction-level reference model driving a per-cycle
// expected-bus queue; directed programs plus a random-memory run.
module tb_dj8_cpu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data_in;
    logic [15:0] address_out;
    logic [7:0]  data_out;
    logic        we;
    logic        write_cycle;

    dj8_cpu u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .address_out (address_out),
        .data_out    (data_out),
        .we          (we),
        .write_cycle (write_cycle)
    );

    always #5 clk = ~clk;

    logic [7:0] dmem [0:65535];
    logic [7:0] mmem [0:65535];

    assign data_in = dmem[address_out];

    always @(posedge clk) begin
        if (rst_n && write_cycle) dmem[address_out] = data_out;
    end

    typedef struct packed {
        logic [15:0] a;
        logic        w;
        logic        wc;
        logic [7:0]  d;
    } cyc_t;

    cyc_t       exp_q [$];
    cyc_t       e;
    logic [7:0] mr [0:7];
    bit         mz, mc;
    logic [15:0] mpc;

    int  total = 0;
    int  bad = 0;
    bit  chk_on = 1'b0;
    int  cyc = 0;
    logic [15:0] tr_a  [0:63];
    logic [7:0]  tr_d  [0:63];
    logic        tr_we [0:63];
    logic        tr_wc [0:63];
    logic [7:0]  prog [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic w, input logic wc, input logic [7:0] d);
        cyc_t c;
        c.a = a; c.w = w; c.wc = wc; c.d = d;
        exp_q.push_back(c);
    endtask

    task automatic m_alu(input int op, input int x, input int y, input bit shr, output logic [7:0] r);
        int s;
        int cn;
        cn = int'(mc);
        case (op)
            0: s = x + y;
            1: s = x + y + int'(mc);
            2: s = x - y - int'(mc);
            3: s = x - y;
            4: s = x ^ y;
            5: s = x | y;
            6: s = x & y;
            default: s = y;
        endcase
        if (op < 2) cn = (s > 255) ? 1 : 0;
        else if (op < 4) cn = (s < 0) ? 1 : 0;
        s = s & 255;
        if (shr) begin
            cn = s & 1;
            s = s >> 1;
        end
        mc = (cn != 0);
        mz = (s == 0);
        r = s[7:0];
    endtask

    // Execute one whole instruction and queue the bus cycles it must produce.
    task automatic model_step();
        logic [7:0]  hi, lo, v;
        logic [15:0] a1, ea, ptr;
        int op, d, s;
        bit taken, shr;
        a1 = mpc + 16'd1;
        hi = mmem[mpc];
        lo = mmem[a1];
        push(mpc, 0, 0, 0);
        push(a1, 0, 0, 0);
        mpc = mpc + 16'd2;
        ea = mpc;
        op = int'(hi[5:3]);
        d  = int'(hi[2:0]);
        s  = int'(lo[7:5]);
        if (hi < 8'h10) begin
            push(ea, 0, 0, 0);
        end else if (hi < 8'h40) begin
            taken = (hi[7:4] == 4'd3) || (hi[7:4] == 4'd1 && mz) || (hi[7:4] == 4'd2 && !mz);
            push(ea, 0, 0, 0);
            if (taken) mpc = {mpc[15:13], hi[3:0], lo, 1'b0};
        end else if (hi < 8'h80) begin
            push(ea, 0, 0, 0);
            mpc = {mr[6], mr[7]};
        end else if (hi < 8'hC0) begin
            shr = 1'b0;
`ifdef DJ8_SHIFT_EN
            shr = lo[2];
`endif
            ptr = lo[4] ? {mr[4], mr[5]} : {mr[6], mr[7]};
            if (op == 7 && lo[0]) begin
                v = shr ? (mr[s] >> 1) : mr[s];
                push(ptr, 1, 0, 0);
                push(ptr, 1, 1, v);
                mmem[ptr] = v;
            end else if (op == 7 && lo[1]) begin
                push(ptr, 0, 0, 0);
                mr[d] = mmem[ptr];
                mz = (mr[d] == 8'd0);
            end else begin
                push(ea, 0, 0, 0);
                m_alu(op, int'(mr[s]), (op == 7) ? int'(mr[s]) : int'(mr[0]), shr, v);
                mr[d] = v;
            end
        end else begin
            push(ea, 0, 0, 0);
            m_alu(op, int'(mr[d]), int'(lo), 1'b0, v);
            mr[d] = v;
        end
    endtask

    // Per-cycle comparison of the bus against the model's expected cycles.
    always @(negedge clk) begin
        #1;
        if (chk_on) begin
            if (exp_q.size() == 0) model_step();
            e = exp_q.pop_front();
            chk("addr", 32'(address_out), 32'(e.a));
            chk("we", 32'(we), 32'(e.w));
            chk("wcyc", 32'(write_cycle), 32'(e.wc));
            if (e.wc) chk("dout", 32'(data_out), 32'(e.d));
            if (cyc < 64) begin
                tr_a[cyc] = address_out;
                tr_d[cyc] = data_out;
                tr_we[cyc] = we;
                tr_wc[cyc] = write_cycle;
            end
            cyc++;
        end
    end

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < 65536; i++) begin
            dmem[i] = rnd ? 8'($urandom) : 8'd0;
            mmem[i] = dmem[i];
        end
    endtask

    task automatic load_prog(input logic [15:0] base);
        logic [15:0] a;
        a = base;
        foreach (prog[i]) begin
            dmem[a] = prog[i];
            mmem[a] = prog[i];
            a = a + 16'd1;
        end
    endtask

    task automatic start();
        rst_n = 1'b0;
        chk_on = 1'b0;
        mpc = 16'h8000;
        for (int i = 0; i < 8; i++) mr[i] = 8'd0;
        mz = 1'b0;
        mc = 1'b0;
        exp_q.delete();
        cyc = 0;
        @(negedge clk);
        chk("rst_addr", 32'(address_out), 32'h8000);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_wcyc", 32'(write_cycle), 32'd0);
        chk("rst_dout", 32'(data_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_on = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
        chk_on = 1'b0;
        #2;
    endtask

    initial begin
        // movi A,5 ; add A,0xFB ; jz 0x083
        fill_mem(0);
        prog = '{8'hF8, 8'h05, 8'hC0, 8'hFB, 8'h10, 8'h83};
        load_prog(16'h8000);
        start();
        run(10);
        chk("t1_fetch0", 32'(tr_a[0]), 32'h8000);
        chk("t1_fetch1", 32'(tr_a[1]), 32'h8001);
        chk("t1_jz_target", 32'(tr_a[9]), 32'h8106);
        chk("t1_model_a", 32'(mr[0]), 32'h00);
        chk("t1_model_z", 32'(mz), 32'd1);
        chk("t1_model_c", 32'(mc), 32'd1);

        // G=0x80 H=0x10 A=0xAA ; store A at GH
        fill_mem(0);
        prog = '{8'hFE, 8'h80, 8'hFF, 8'h10, 8'hF8, 8'hAA, 8'hB8, 8'h01};
        load_prog(16'h8000);
        start();
        run(14);
        chk("t2_exec_addr", 32'(tr_a[11]), 32'h8010);
        chk("t2_exec_we", 32'(tr_we[11]), 32'd1);
        chk("t2_exec_wcyc", 32'(tr_wc[11]), 32'd0);
        chk("t2_write_wcyc", 32'(tr_wc[12]), 32'd1);
        chk("t2_write_data", 32'(tr_d[12]), 32'hAA);
        chk("t2_next_fetch", 32'(tr_a[13]), 32'h8008);
        chk("t2_mem", 32'(dmem[16'h8010]), 32'hAA);

        // E=0x40 F=0 B=7 ; load B from EF (value 0) ; jnz not taken
        fill_mem(0);
        prog = '{8'hFC, 8'h40, 8'hFD, 8'h00, 8'hF9, 8'h07, 8'hB9, 8'h12, 8'h20, 8'h40};
        load_prog(16'h8000);
        start();
        run(16);
        chk("t3_load_addr", 32'(tr_a[11]), 32'h4000);
        chk("t3_jnz_fallthru", 32'(tr_a[15]), 32'h800A);
        chk("t3_model_b", 32'(mr[1]), 32'h00);
        chk("t3_model_z", 32'(mz), 32'd1);

        // A=0x81 ; movr A,A,shr ; store A ; B=0 ; addc B,0 ; store B
        fill_mem(0);
        prog = '{8'hFE, 8'h80, 8'hFF, 8'h10, 8'hF8, 8'h81, 8'hB8, 8'h04,
                 8'hB8, 8'h01, 8'hF9, 8'h00, 8'hC9, 8'h00, 8'hB8, 8'h21};
        load_prog(16'h8000);
        start();
        run(26);
`ifdef DJ8_SHIFT_EN
        chk("t4_shifted_a", 32'(tr_d[15]), 32'h40);
        chk("t4_carry_out", 32'(tr_d[25]), 32'h01);
`else
        chk("t4_unshifted_a", 32'(tr_d[15]), 32'h81);
        chk("t4_carry_kept", 32'(tr_d[25]), 32'h00);
`endif

        // G=0x12 H=0x34 ; jmp GH
        fill_mem(0);
        prog = '{8'hFE, 8'h12, 8'hFF, 8'h34, 8'h60, 8'h00};
        load_prog(16'h8000);
        start();
        run(10);
        chk("t5_jmp_gh", 32'(tr_a[9]), 32'h1234);

        // jmp GH to 0xFFFE, then PC+2 wraps to 0x0000
        fill_mem(0);
        prog = '{8'hFE, 8'hFF, 8'hFF, 8'hFE, 8'h60, 8'h00};
        load_prog(16'h8000);
        start();
        run(14);
        chk("t6_fetch_fffe", 32'(tr_a[9]), 32'hFFFE);
        chk("t6_fetch_ffff", 32'(tr_a[10]), 32'hFFFF);
        chk("t6_wrap_exec", 32'(tr_a[11]), 32'h0000);
        chk("t6_wrap_fetch", 32'(tr_a[12]), 32'h0000);

        // jmp 0x8AF keeps PC[15:13]
        fill_mem(0);
        prog = '{8'h38, 8'hAF};
        load_prog(16'h8000);
        start();
        run(4);
        chk("t7_jmp_imm", 32'(tr_a[3]), 32'h915E);

        // asynchronous reset during the store EXEC cycle
        fill_mem(0);
        prog = '{8'hFE, 8'h80, 8'hFF, 8'h10, 8'hF8, 8'hAA, 8'hB8, 8'h01};
        load_prog(16'h8000);
        start();
        repeat (11) @(negedge clk);
        chk_on = 1'b0;
        #2;
        chk("t8_we_before", 32'(we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t8_we_dropped", 32'(we), 32'd0);
        chk("t8_addr_reset", 32'(address_out), 32'h8000);
        chk("t8_wcyc_reset", 32'(write_cycle), 32'd0);

        // random memory contents executed from reset
        for (int r = 0; r < 3; r++) begin
            fill_mem(1);
            start();
            run(4000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
